// File: rtl/rsg_pkg.sv
// Shared types and elaboration helpers for the random symbol-sequence generator.
package rsg_pkg;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int cand_w(input int num_sym);
    return $clog2(num_sym);
  endfunction

  // Fibonacci feedback masks for maximal-length sequences; zero flags an unsupported width.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/rsg_lfsr.sv
// Free-running Fibonacci LFSR with run-time reload; a zero seed falls back to SEED.
// Latency: load/shift visible the cycle after; no backpressure, shifts every cycle.
module rsg_lfsr
  import rsg_pkg::*;
#(
  parameter int              W     = 16,
  parameter int              OUT_W = 3,
  parameter logic [W-1:0]    SEED  = 'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     seed_in,
  output logic [OUT_W-1:0] cand
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  if (TAPS == '0 || OUT_W > W) begin : g_param_err
    $error("rsg_lfsr: unsupported LFSR width");
  end

  logic [W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= (seed_in == '0) ? SEED : seed_in;
    end else begin
      lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS)};
    end
  end

  assign cand = lfsr[OUT_W-1:0];

endmodule

// File: rtl/rand_seq_gen.sv
// Fills up to MAX_LEN symbols (1..NUM_SYM) from an LFSR with range rejection; RSG_RUN_LIMIT_EN caps runs at MAX_RUN.
// Latency: len_l+2 cycles from start plus one per rejected draw; start is ignored while busy.
module rand_seq_gen
  import rsg_pkg::*;
#(
  parameter int                  SYM_W   = 4,
  parameter int                  MAX_LEN = 8,
  parameter int                  NUM_SYM = 8,
  parameter int                  MAX_RUN = 2,
  parameter int                  LFSR_W  = 16,
  parameter logic [LFSR_W-1:0]   SEED    = 'hACE1,
  localparam int                 LEN_W   = len_w(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed_in,
  output logic                     busy,
  output logic                     seq_ready,
  output logic [LEN_W-1:0]         seq_len,
  output logic [SYM_W*MAX_LEN-1:0] seq_out
);

  localparam int CAND_W = cand_w(NUM_SYM);

  if (NUM_SYM < 2 || NUM_SYM > (1 << SYM_W) - 1 || MAX_RUN < 1 || SEED == '0) begin : g_param_err
    $error("rand_seq_gen: invalid parameter combination");
  end

  state_t             state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_l;
  logic [LEN_W-1:0]   len_clamp;
  logic [CAND_W-1:0]  cand;
  logic [SYM_W-1:0]   sym;
  logic               in_range;
  logic               run_block;
  logic               accept;

  rsg_lfsr #(
    .W     (LFSR_W),
    .OUT_W (CAND_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seed_load),
    .seed_in (seed_in),
    .cand    (cand)
  );

  assign len_clamp = (int'(len) > MAX_LEN) ? LEN_W'(MAX_LEN) : len;
  assign sym       = SYM_W'(cand) + SYM_W'(1);
  assign in_range  = int'(cand) < NUM_SYM;

`ifdef RSG_RUN_LIMIT_EN
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  logic [RUN_W-1:0] run;
  logic [SYM_W-1:0] last;

  assign run_block = (cnt != '0) && (sym == last) && (run == RUN_W'(MAX_RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= '0;
      last <= '0;
    end else if (state == IDLE && start) begin
      run  <= '0;
      last <= '0;
    end else if (state == GEN && cnt != len_l && accept) begin
      run  <= (cnt == '0 || sym != last) ? RUN_W'(1) : run + RUN_W'(1);
      last <= sym;
    end
  end
`else
  assign run_block = 1'b0;
`endif

  assign accept = in_range && !run_block;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_l     <= '0;
      seq_out   <= '0;
      seq_len   <= '0;
      seq_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      seq_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seq_out <= '0;
            cnt     <= '0;
            len_l   <= len_clamp;
            busy    <= 1'b1;
            state   <= GEN;
          end
        end
        GEN: begin
          if (cnt == len_l) begin
            seq_ready <= 1'b1;
            seq_len   <= len_l;
            state     <= DONE;
          end else if (accept) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (cnt == LEN_W'(i)) seq_out[i*SYM_W +: SYM_W] <= sym;
            end
            cnt <= cnt + LEN_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_seq_gen.sv
// Scoreboard bench: two generators (8-symbol/run 2, 5-symbol/run 1) share stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_rand_seq_gen;

  localparam int          MAX_LEN = 8;
  localparam int          LEN_W   = 4;
  localparam int          BUDGET  = 16 * MAX_LEN;
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef RSG_RUN_LIMIT_EN
  localparam bit RUN_EN = 1'b1;
`else
  localparam bit RUN_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] seq;
    int          len_l;
    int          lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             seed_load = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0]      seed_in = '0;
  logic             busy_a, rdy_a, busy_b, rdy_b;
  logic [LEN_W-1:0] slen_a, slen_b;
  logic [31:0]      seq_a, seq_b;
  logic [15:0]      m_lfsr;
  exp_t             q_a[$];
  exp_t             q_b[$];
  int               n_checks = 0;
  int               n_errors = 0;

  always #5 clk = ~clk;

  rand_seq_gen #(.NUM_SYM(8), .MAX_RUN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .seed_load(seed_load),
    .seed_in(seed_in), .busy(busy_a), .seq_ready(rdy_a), .seq_len(slen_a), .seq_out(seq_a)
  );

  rand_seq_gen #(.NUM_SYM(5), .MAX_RUN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .seed_load(seed_load),
    .seed_in(seed_in), .busy(busy_b), .seq_ready(rdy_b), .seq_len(slen_b), .seq_out(seq_b)
  );

  function automatic logic [15:0] shift16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR tracking every clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         m_lfsr <= SEED;
    else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? SEED : seed_in;
    else                m_lfsr <= shift16(m_lfsr);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [15:0] l0, input int ln, input int nsym, input int mrun);
    exp_t        e;
    logic [15:0] l = l0;
    int          cnt = 0, run = 0, last = 0, c, sym, cw;
    bit          acc;
    cw      = $clog2(nsym);
    e.len_l = (ln > MAX_LEN) ? MAX_LEN : ln;
    e.seq   = '0;
    e.lat   = 2;
    while (cnt < e.len_l && e.lat < 10000) begin
      c   = int'(l) & ((1 << cw) - 1);
      sym = c + 1;
      acc = c < nsym;
      if (RUN_EN && acc && cnt > 0 && sym == last && run == mrun) acc = 1'b0;
      if (acc) begin
        e.seq[cnt*4 +: 4] = 4'(sym);
        run  = (cnt == 0 || sym != last) ? 1 : run + 1;
        last = sym;
        cnt++;
      end
      l = shift16(l);
      e.lat++;
    end
    return e;
  endfunction

  function automatic bit syms_ok(input logic [31:0] s, input int n, input int nsym);
    bit ok = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < n && (s[i*4 +: 4] < 1 || s[i*4 +: 4] > nsym)) ok = 1'b0;
      if (i >= n && s[i*4 +: 4] != 0) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int longest_run(input logic [31:0] s, input int n);
    int best = 0, cur = 0;
    for (int i = 0; i < n; i++) begin
      cur  = (i > 0 && s[i*4 +: 4] == s[(i-1)*4 +: 4]) ? cur + 1 : 1;
      best = (cur > best) ? cur : best;
    end
    return best;
  endfunction

  task automatic do_run(input int ln, input bit ld, input logic [15:0] sd, input bit poke,
                        output logic [31:0] exp_seq_a);
    exp_t ea, eb, ga, gb;
    int   k = 1;
    bit   got_a = 1'b0, got_b = 1'b0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(ln); seed_load = ld; seed_in = sd;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    ea = predict(m_lfsr, ln, 8, 2);
    eb = predict(m_lfsr, ln, 5, 1);
    q_a.push_back(ea);
    q_b.push_back(eb);
    exp_seq_a = ea.seq;
    check_val("busy_rise_a", busy_a, 1);
    while (!(got_a && got_b) && k <= BUDGET) begin
      if (poke) start = (k == 3 || k == 4);
      if (got_a) check_val("rdy_once_a", rdy_a, 0);
      if (got_b) check_val("rdy_once_b", rdy_b, 0);
      if (rdy_a && !got_a) begin
        got_a = 1'b1;
        ga = q_a.pop_front();
        check_val("seq_a", seq_a, ga.seq);
        check_val("len_a", slen_a, ga.len_l);
        check_val("lat_a", k, ga.lat);
        check_val("range_a", syms_ok(seq_a, ga.len_l, 8), 1);
        check_val("runcap_a", longest_run(seq_a, ga.len_l) <= (RUN_EN ? 2 : MAX_LEN), 1);
      end
      if (rdy_b && !got_b) begin
        got_b = 1'b1;
        gb = q_b.pop_front();
        check_val("seq_b", seq_b, gb.seq);
        check_val("len_b", slen_b, gb.len_l);
        check_val("lat_b", k, gb.lat);
        check_val("range_b", syms_ok(seq_b, gb.len_l, 5), 1);
        check_val("runcap_b", longest_run(seq_b, gb.len_l) <= (RUN_EN ? 1 : MAX_LEN), 1);
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check_val("timeout_a", got_a, 1);
    check_val("timeout_b", got_b, 1);
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_a", busy_a, 0);
    check_val("idle_b", busy_b, 0);
    check_val("hold_a", seq_a, ea.seq);
    check_val("hold_b", seq_b, eb.seq);
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    logic [31:0] s1, s2;
    int          k;

    #12;
    check_val("rst_seq_a", seq_a, 0);
    check_val("rst_len_a", slen_a, 0);
    check_val("rst_rdy_a", rdy_a, 0);
    check_val("rst_busy_a", busy_a, 0);
    check_val("rst_seq_b", seq_b, 0);
    check_val("rst_busy_b", busy_b, 0);
    check_val("rst_lfsr", dut_a.u_lfsr.lfsr, SEED);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("lfsr_track", dut_a.u_lfsr.lfsr, m_lfsr);

    do_run(8, 1'b0, 16'h0, 1'b0, s1);
    do_run(15, 1'b0, 16'h0, 1'b0, s1);
    do_run(0, 1'b0, 16'h0, 1'b0, s1);

    @(negedge clk); seed_load = 1'b1; seed_in = 16'h0;
    @(posedge clk); #1; seed_load = 1'b0;
    check_val("seed_zero", dut_a.u_lfsr.lfsr, SEED);

    do_run(6, 1'b1, 16'h1234, 1'b0, s1);
    do_run(6, 1'b1, 16'h1234, 1'b0, s2);
    check_val("seed_repeat", seq_a, s1);

    do_run(8, 1'b0, 16'h0, 1'b1, s1);

    // Reset in the middle of generation
    @(negedge clk); start = 1'b1; len = 4'd8;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (dut_a.cnt != 3 && k < BUDGET) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("reach_cnt3", dut_a.cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_seq_a", seq_a, 0);
    check_val("mid_rst_len_a", slen_a, 0);
    check_val("mid_rst_busy_a", busy_a, 0);
    check_val("mid_rst_rdy_a", rdy_a, 0);
    check_val("mid_rst_busy_b", busy_b, 0);
    check_val("mid_rst_lfsr", dut_a.u_lfsr.lfsr, SEED);
    @(negedge clk); rst_n = 1'b1;
    do_run(8, 1'b0, 16'h0, 1'b0, s1);

    for (int i = 0; i < 200; i++) begin
      do_run(8, 1'b1, 16'($urandom_range(0, 65535)), 1'b0, s1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
